alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential execute unit for copperv: single-cycle integer ops plus iterative RV32M multiply/divide behind a valid/ready handshake. It sits in the execute stage in place of the purely combinational ALU. It registers every result. Stall, flush and backpressure are handled locally, so the core can issue multi-cycle ops without a global stall scheme.

## Interface
- `XLEN`, default 32: datapath width. Legal values are 32 and 64. Shift amount width is $clog2(XLEN).
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `flush` in 1: abort any in-flight op and drop any pending result.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request this cycle.
- `op` in `alu_op_e`: operation.
- `din1` in XLEN: operand 1 (rs1 / dividend / multiplicand).
- `din2` in XLEN: operand 2 (rs2 / divisor / multiplier).
- `out_valid` out 1: `dout` holds a result.
- `out_ready` in 1: consumer takes the result this cycle.
- `dout` out XLEN: result.
- `busy` out 1: a mul/div iteration is in progress.
- `comp_eq`, `comp_lt`, `comp_ltu` out 1 each: combinational compares of `din1`/`din2`, independent of the handshake (used by branch logic).

## Operation
- Basic ops: NOP, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Computed combinationally and captured into `dout` on accept.
  - Shifts use `din2[$clog2(XLEN)-1:0]`.
  - SRA is arithmetic; SLT is signed; SLTU is unsigned. Both compares zero-extend a 1-bit result.
- Multiply ops: MUL, MULH, MULHSU, MULHU.
  - Radix-2 shift-add on operand magnitudes, 2·XLEN-bit product.
  - Result is negated in the FIX state when the sign rule requires it.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits. MULHSU treats `din1` as signed and `din2` as unsigned.
- Divide/remainder ops: DIV, DIVU, REM, REMU.
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Sign correction in FIX: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
- Special cases, resolved in FIX without changing latency:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- FSM states:
  - IDLE: accepts requests.
    - Basic op goes to DONE.
    - Mul/div op latches operands and signs, clears the counter, goes to ITER.
  - ITER: one step per cycle. After XLEN steps (counter = XLEN−1), goes to FIX.
  - FIX: sign/special-case correction, load `dout`, go to DONE.
  - DONE: `out_valid`=1.
    - With `out_ready`=1: go to IDLE, or accept a new request in the same cycle.
    - With `out_ready`=0: hold.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). A request is accepted when `in_valid` & `in_ready`.
- `flush` has priority over everything. Next state is IDLE, `out_valid` goes to 0, and a request presented in the same cycle is not accepted.
- An unknown `op` behaves as a basic op with `dout`=0.

## Timing
- Reset: state=IDLE, `out_valid`=0, `dout`=0, `busy`=0, counter=0. `in_ready`=1 the cycle after reset deasserts.
- Accept at edge N:
  - Basic op: `out_valid`=1 from cycle N+1.
  - Mul/div (all cases, including specials): `out_valid`=1 from cycle N+XLEN+2. That is 34 cycles for XLEN=32.
- `busy`=1 in ITER and FIX only.
- While `out_valid`=1 & `out_ready`=0, `dout` and `out_valid` stay stable every cycle.
- Back-to-back basic ops with `out_ready` tied high give one result per cycle.
- Reset or flush mid-iteration discards partial state. The next accepted op produces a correct result with nominal latency.

## Structure
- `copperv_pkg` additions:
  - `alu_op_e` extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - State typedef `alu_seq_state_e`.
  - Helper predicates `is_mul(op)` and `is_div(op)`.
- Sub-module `muldiv_iter` holds the iterative datapath: operand/accumulator registers, counter and step logic. It takes start/op/operands and returns raw magnitude results. `alu_seq` owns the FSM, handshake, basic ops and FIX stage.

## Test plan
- Reset then basic ops with `out_ready`=1: ADD 5+7 -> 12 at N+1. SRA 0x80000000>>>4 -> 0xF8000000. SLT −1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU −1 × 0xFFFFFFFF -> 0xFFFFFFFF. MUL 3×−4 -> 0xFFFFFFF4. Each has `out_valid` exactly at N+34.
- DIV −7/2 -> −3 and REM -> −1. DIVU 7/0 -> 0xFFFFFFFF and REMU -> 7. DIV 0x80000000/−1 -> 0x80000000 and REM -> 0. All at N+34.
- Backpressure: hold `out_ready`=0 for 5 cycles after a DIV result. `dout` and `out_valid` stay stable and `in_ready`=0. Raising `out_ready` together with `in_valid` (ADD 1+1) accepts it, and 2 appears the next cycle.
- Flush at iteration 10 of a DIVU. `out_valid` never rises, `in_ready`=1 next cycle, and a following MULHU 0xFFFFFFFF×2 -> 1 at nominal latency.
- Reset (`rstn`=0 for one edge) mid-MUL: all outputs return to reset values on that edge and no stale result appears afterwards.

Source files
------------

// File: rtl/copperv_pkg.sv
// Shared types for the copperv execute stage: ALU opcodes, sequential ALU
// state encoding and small opcode classification helpers.
package copperv_pkg;

    typedef enum logic [4:0] {
        ALU_NOP    = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_AND    = 5'd3,
        ALU_OR     = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SLL    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_SLT    = 5'd9,
        ALU_SLTU   = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } alu_seq_state_e;

    function automatic logic is_mul(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div(alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // din1 is interpreted as two's complement for these ops
    function automatic logic op_a_signed(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    // din2 is interpreted as two's complement for these ops
    function automatic logic op_b_signed(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute stage and the sequential ALU.
interface alu_seq_if import copperv_pkg::*; #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    alu_op_e         op;
    logic [XLEN-1:0] din1;
    logic [XLEN-1:0] din2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] dout;
    logic            busy;
    logic            comp_eq;
    logic            comp_lt;
    logic            comp_ltu;

    modport master (
        output flush, in_valid, op, din1, din2, out_ready,
        input  in_ready, out_valid, dout, busy, comp_eq, comp_lt, comp_ltu
    );

    modport slave (
        input  flush, in_valid, op, din1, din2, out_ready,
        output in_ready, out_valid, dout, busy, comp_eq, comp_lt, comp_ltu
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per step.
// Multiply: {acc_hi, acc_lo} ends as the 2*XLEN product of the magnitudes.
// Divide:   acc_lo ends as the quotient and acc_hi as the remainder.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic              last,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] operand;
    logic            mode_div;
    logic [CW-1:0]   cnt;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic [XLEN-1:0] next_hi;
    logic [XLEN-1:0] next_lo;

    // Next accumulator value for one shift-add or one restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, operand});
        div_sub   = div_shift[XLEN-1:0] - operand;
        if (mode_div) begin
            next_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            next_hi = mul_sum[XLEN:1];
            next_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Load operands on start, then advance one step per enabled cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            mode_div <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            acc_hi   <= '0;
            acc_lo   <= div_mode ? a_mag : b_mag;
            operand  <= div_mode ? b_mag : a_mag;
            mode_div <= div_mode;
            cnt      <= '0;
        end else if (step) begin
            acc_hi   <= next_hi;
            acc_lo   <= next_lo;
            cnt      <= cnt + 1'b1;
        end
    end

    assign last      = (cnt == LAST_CNT);
    assign product   = {acc_hi, acc_lo};
    assign quotient  = acc_lo;
    assign remainder = acc_hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential execute unit: single-cycle integer ops plus iterative RV32M
// multiply/divide behind a valid/ready handshake with registered results.
module alu_seq import copperv_pkg::*; #(
    parameter int XLEN = 32
) (
    input logic    clk,
    input logic    rstn,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_seq_state_e  state;
    logic            out_valid_r;
    logic            busy_r;
    logic [XLEN-1:0] dout_r;

    alu_op_e         op_r;
    logic            neg_a_r;
    logic            neg_b_r;
    logic            b_zero_r;
    logic            ovf_r;
    logic [XLEN-1:0] a_orig_r;

    logic            accept;
    logic            is_md;
    logic            start_md;
    logic            iter_step;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic [XLEN-1:0] basic_result;
    logic [XLEN-1:0] fix_result;
    logic [2*XLEN-1:0] prod_signed;

    logic              iter_last;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;

    assign cmp_eq  = (bus.din1 == bus.din2);
    assign cmp_lt  = ($signed(bus.din1) < $signed(bus.din2));
    assign cmp_ltu = (bus.din1 < bus.din2);

    assign bus.comp_eq   = cmp_eq;
    assign bus.comp_lt   = cmp_lt;
    assign bus.comp_ltu  = cmp_ltu;
    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.busy      = busy_r;

    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
    assign is_md     = is_mul(bus.op) || is_div(bus.op);
    assign start_md  = accept && is_md;
    assign iter_step = (state == ST_ITER);

    // Operand signs and magnitudes fed to the iterative datapath
    always_comb begin
        a_neg = op_a_signed(bus.op) && bus.din1[XLEN-1];
        b_neg = op_b_signed(bus.op) && bus.din2[XLEN-1];
        a_mag = a_neg ? (~bus.din1 + 1'b1) : bus.din1;
        b_mag = b_neg ? (~bus.din2 + 1'b1) : bus.din2;
    end

    // Single-cycle ops; unknown opcodes produce zero
    always_comb begin
        basic_result = '0;
        case (bus.op)
            ALU_ADD:  basic_result = bus.din1 + bus.din2;
            ALU_SUB:  basic_result = bus.din1 - bus.din2;
            ALU_AND:  basic_result = bus.din1 & bus.din2;
            ALU_OR:   basic_result = bus.din1 | bus.din2;
            ALU_XOR:  basic_result = bus.din1 ^ bus.din2;
            ALU_SLL:  basic_result = bus.din1 << bus.din2[SW-1:0];
            ALU_SRL:  basic_result = bus.din1 >> bus.din2[SW-1:0];
            ALU_SRA:  basic_result = $signed(bus.din1) >>> bus.din2[SW-1:0];
            ALU_SLT:  basic_result = {{(XLEN-1){1'b0}}, cmp_lt};
            ALU_SLTU: basic_result = {{(XLEN-1){1'b0}}, cmp_ltu};
            default:  basic_result = '0;
        endcase
    end

    // Sign correction and divide special cases applied to the raw magnitudes
    always_comb begin
        prod_signed = (neg_a_r ^ neg_b_r) ? (~product + 1'b1) : product;
        fix_result  = '0;
        case (op_r)
            ALU_MUL: fix_result = prod_signed[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_result = prod_signed[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU: begin
                if (b_zero_r)
                    fix_result = '1;
                else if (ovf_r)
                    fix_result = a_orig_r;
                else
                    fix_result = (neg_a_r ^ neg_b_r) ? (~quotient + 1'b1) : quotient;
            end
            ALU_REM, ALU_REMU: begin
                if (b_zero_r)
                    fix_result = a_orig_r;
                else if (ovf_r)
                    fix_result = '0;
                else
                    fix_result = neg_a_r ? (~remainder + 1'b1) : remainder;
            end
            default: fix_result = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start_md),
        .step      (iter_step),
        .div_mode  (is_div(bus.op)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .last      (iter_last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Control FSM with registered result, valid and busy; flush beats everything but reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            dout_r      <= '0;
            op_r        <= ALU_NOP;
            neg_a_r     <= 1'b0;
            neg_b_r     <= 1'b0;
            b_zero_r    <= 1'b0;
            ovf_r       <= 1'b0;
            a_orig_r    <= '0;
        end else if (bus.flush) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_md) begin
                            state       <= ST_ITER;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b1;
                            op_r        <= bus.op;
                            neg_a_r     <= a_neg;
                            neg_b_r     <= b_neg;
                            b_zero_r    <= (bus.din2 == '0);
                            ovf_r       <= op_a_signed(bus.op) && is_div(bus.op) &&
                                           (bus.din1 == MOST_NEG) && (bus.din2 == '1);
                            a_orig_r    <= bus.din1;
                        end else begin
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                            dout_r      <= basic_result;
                        end
                    end else if ((state == ST_DONE) && bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (iter_last)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    dout_r      <= fix_result;
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written handshake corner sequences.
module tb_alu_seq;
    import copperv_pkg::*;

    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 1;
    localparam int NV     = 22;

    logic clk = 1'b0;
    logic rstn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_seq_if #(.XLEN(XLEN)) bus();

    alu_seq #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // Reference results computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(alu_op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            ALU_MUL:    begin p = sa * sb; return p[31:0]; end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            ALU_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            ALU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            ALU_REMU: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(alu_op_e op);
        return (op >= ALU_MUL && op <= ALU_REMU) ? MD_LAT : 0;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 9));
            3:       return 32'd0 - 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request with out_ready high and wait (bounded) for its result
    task automatic applyStimulus(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] result, output int lat);
        bus.op        = op;
        bus.din1      = a;
        bus.din2      = b;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        result = bus.dout;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [NV];
        logic [31:0] res;
        int          lat;
        int          seen;
        alu_op_e     rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  cmp_exp;

        vecs[0]  = '{ALU_ADD,    32'd5,          32'd7,          32'd12,         0};
        vecs[1]  = '{ALU_SUB,    32'd5,          32'd7,          32'hFFFF_FFFE,  0};
        vecs[2]  = '{ALU_AND,    32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  0};
        vecs[3]  = '{ALU_OR,     32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34,  0};
        vecs[4]  = '{ALU_XOR,    32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF00_ED34,  0};
        vecs[5]  = '{ALU_SLL,    32'd1,          32'd35,         32'd8,          0};
        vecs[6]  = '{ALU_SRL,    32'h8000_0000,  32'd4,          32'h0800_0000,  0};
        vecs[7]  = '{ALU_SRA,    32'h8000_0000,  32'd4,          32'hF800_0000,  0};
        vecs[8]  = '{ALU_SLT,    32'hFFFF_FFFF,  32'd1,          32'd1,          0};
        vecs[9]  = '{ALU_SLTU,   32'hFFFF_FFFF,  32'd1,          32'd0,          0};
        vecs[10] = '{ALU_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MD_LAT};
        vecs[11] = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  MD_LAT};
        vecs[12] = '{ALU_MUL,    32'd3,          32'hFFFF_FFFC,  32'hFFFF_FFF4,  MD_LAT};
        vecs[13] = '{ALU_MULHU,  32'hFFFF_FFFF,  32'd2,          32'd1,          MD_LAT};
        vecs[14] = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  MD_LAT};
        vecs[15] = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  MD_LAT};
        vecs[16] = '{ALU_DIVU,   32'd7,          32'd0,          32'hFFFF_FFFF,  MD_LAT};
        vecs[17] = '{ALU_REMU,   32'd7,          32'd0,          32'd7,          MD_LAT};
        vecs[18] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  MD_LAT};
        vecs[19] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          MD_LAT};
        vecs[20] = '{ALU_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  MD_LAT};
        vecs[21] = '{alu_op_e'(5'd31), 32'd9,    32'd9,          32'd0,          0};

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = ALU_NOP;
        bus.din1      = '0;
        bus.din2      = '0;
        rstn          = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset dout",      bus.dout,               32'd0);
        checkOutput("reset busy",      {31'b0, bus.busy},      32'd0);
        checkOutput("reset in_ready",  {31'b0, bus.in_ready},  32'd1);

        // Directed vector table, including combinational compares
        for (int i = 0; i < NV; i++) begin
            bus.din1 = vecs[i].a;
            bus.din2 = vecs[i].b;
            #1;
            cmp_exp = {vecs[i].a == vecs[i].b,
                       $signed(vecs[i].a) < $signed(vecs[i].b),
                       vecs[i].a < vecs[i].b};
            checkOutput($sformatf("vec%0d compares", i),
                        {29'b0, bus.comp_eq, bus.comp_lt, bus.comp_ltu}, {29'b0, cmp_exp});
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            checkOutput($sformatf("vec%0d dout", i),    res,       vecs[i].exp);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat),  32'(vecs[i].lat));
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = alu_op_e'($urandom_range(1, 18));
            ra  = pick_operand();
            rb  = pick_operand();
            applyStimulus(rop, ra, rb, res, lat);
            checkOutput($sformatf("rand%0d %s 0x%08h,0x%08h dout", i, rop.name(), ra, rb),
                        res, ref_model(rop, ra, rb));
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_latency(rop)));
        end

        // Back-to-back basic ops give one result per cycle
        bus.out_ready = 1'b1;
        bus.op        = ALU_ADD;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din1 = 32'(i * 3);
            bus.din2 = 32'd100;
            tick();
            checkOutput($sformatf("b2b%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            checkOutput($sformatf("b2b%0d dout", i),      bus.dout,               32'(i * 3 + 100));
        end
        bus.in_valid = 1'b0;
        tick();

        // Backpressure after a DIV result
        bus.op        = ALU_DIV;
        bus.din1      = 32'hFFFF_FFF9;
        bus.din2      = 32'd2;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        repeat (5) begin tick(); lat++; end
        checkOutput("bp busy mid-iteration", {31'b0, bus.busy}, 32'd1);
        while (bus.out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        checkOutput("bp latency",   32'(lat),          32'(MD_LAT));
        checkOutput("bp busy done", {31'b0, bus.busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp hold%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            checkOutput($sformatf("bp hold%0d dout", i),      bus.dout,               32'hFFFF_FFFD);
            checkOutput($sformatf("bp hold%0d in_ready", i),  {31'b0, bus.in_ready},  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.op        = ALU_ADD;
        bus.din1      = 32'd1;
        bus.din2      = 32'd1;
        bus.in_valid  = 1'b1;
        #1;
        checkOutput("bp release in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("bp next out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("bp next dout",      bus.dout,               32'd2);
        tick();

        // Flush at iteration 10 of a DIVU, with a competing request
        bus.op       = ALU_DIVU;
        bus.din1     = 32'd100;
        bus.din2     = 32'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        bus.flush    = 1'b1;
        bus.op       = ALU_ADD;
        bus.in_valid = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("flush in_ready",  {31'b0, bus.in_ready},  32'd1);
        checkOutput("flush busy",      {31'b0, bus.busy},      32'd0);
        seen = 0;
        repeat (40) begin tick(); if (bus.out_valid === 1'b1) seen++; end
        checkOutput("flush no stale result", 32'(seen), 32'd0);
        applyStimulus(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, res, lat);
        checkOutput("post-flush MULHU dout",    res,      32'd1);
        checkOutput("post-flush MULHU latency", 32'(lat), 32'(MD_LAT));

        // Reset in the middle of a MUL
        bus.op       = ALU_MUL;
        bus.din1     = 32'd3;
        bus.din2     = 32'hFFFF_FFFC;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (15) tick();
        rstn = 1'b0;
        tick();
        checkOutput("midrst out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midrst dout",      bus.dout,               32'd0);
        checkOutput("midrst busy",      {31'b0, bus.busy},      32'd0);
        checkOutput("midrst in_ready",  {31'b0, bus.in_ready},  32'd1);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin tick(); if (bus.out_valid === 1'b1) seen++; end
        checkOutput("midrst no stale result", 32'(seen), 32'd0);
        applyStimulus(ALU_MUL, 32'd3, 32'hFFFF_FFFC, res, lat);
        checkOutput("post-reset MUL dout",    res,      32'hFFFF_FFF4);
        checkOutput("post-reset MUL latency", 32'(lat), 32'(MD_LAT));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
